// File: rtl/lsu_io_regs_pkg.sv
// rtl/lsu_io_regs_pkg.sv - shared region codes, reset values and lane helper for the IO register block
package lsu_io_regs_pkg;

    // Region select field inside the LSU byte address
    localparam int REGION_LSB = 12;
    localparam int REGION_MSB = 16;

    typedef enum logic [4:0] {
        REGION_LEDR   = 5'h00,
        REGION_LEDG   = 5'h01,
        REGION_HEX_LO = 5'h02,
        REGION_HEX_HI = 5'h03,
        REGION_LCD    = 5'h04,
        REGION_SW     = 5'h10,
        REGION_BTN    = 5'h11
    } io_region_e;

    localparam logic [31:0] LEDR_RESET = 32'h0000_0000;
    localparam logic [31:0] LEDG_RESET = 32'h0000_0000;
    localparam logic [31:0] LCD_RESET  = 32'h0000_0000;
    // Segments are active-low, so all-ones in bits [6:0] blanks every digit
    localparam logic [31:0] HEX_RESET  = 32'h7F7F_7F7F;

    // Replace only the byte lanes whose mask bit is set
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] result;
        result = old_word;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) begin
                result[8*n +: 8] = new_word[8*n +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lsu_io_regs_btn_debounce.sv
// rtl/lsu_io_regs_btn_debounce.sv - one-bit two-flop synchronizer followed by a saturating debounce counter
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accepted;

    // Bring the raw button into the clock domain
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip on the last one, never wrap
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt      <= '0;
            accepted <= 1'b0;
        end else if (sync2 == accepted) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            accepted <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_btn = accepted;

endmodule

// File: rtl/lsu_io_regs.sv
// rtl/lsu_io_regs.sv - memory-mapped LED/HEX/LCD output registers with synchronized switch and debounced button inputs
module lsu_io_regs
    import lsu_io_regs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_io_valid,
    input  logic        i_io_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_io_rdata,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);

    io_region_e  region;
    logic        wr_en;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hex_lo;
    logic [31:0] hex_hi;
    logic [31:0] lcd;
    logic [31:0] sw_sync1;
    logic [31:0] sw_sync2;
    logic [3:0]  btn_db;
    logic        unused_addr;

    // Only the region field selects a register; the rest of the window mirrors
    assign region      = io_region_e'(i_lsu_addr[REGION_MSB:REGION_LSB]);
    assign unused_addr = ^{i_lsu_addr[31:REGION_MSB+1], i_lsu_addr[REGION_LSB-1:0]};
    assign wr_en       = i_io_valid & i_io_wren;

    // Lane-masked stores into the output registers; input and unmapped regions drop writes
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr   <= LEDR_RESET;
            ledg   <= LEDG_RESET;
            hex_lo <= HEX_RESET;
            hex_hi <= HEX_RESET;
            lcd    <= LCD_RESET;
        end else if (wr_en) begin
            case (region)
                REGION_LEDR:   ledr   <= merge_lanes(ledr,   i_st_data, i_bmask);
                REGION_LEDG:   ledg   <= merge_lanes(ledg,   i_st_data, i_bmask);
                REGION_HEX_LO: hex_lo <= merge_lanes(hex_lo, i_st_data, i_bmask);
                REGION_HEX_HI: hex_hi <= merge_lanes(hex_hi, i_st_data, i_bmask);
                REGION_LCD:    lcd    <= merge_lanes(lcd,    i_st_data, i_bmask);
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer for the switch bank
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= i_io_sw;
            sw_sync2 <= sw_sync1;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_btn  (i_io_btn[b]),
            .o_btn  (btn_db[b])
        );
    end

    // Load data comes straight from current state, so a same-cycle store reads the old value
    always_comb begin
        o_io_rdata = '0;
        if (i_io_valid) begin
            case (region)
                REGION_LEDR:   o_io_rdata = ledr;
                REGION_LEDG:   o_io_rdata = ledg;
                REGION_HEX_LO: o_io_rdata = hex_lo;
                REGION_HEX_HI: o_io_rdata = hex_hi;
                REGION_LCD:    o_io_rdata = lcd;
                REGION_SW:     o_io_rdata = sw_sync2;
                REGION_BTN:    o_io_rdata = {28'b0, btn_db};
                default:       o_io_rdata = '0;
            endcase
        end
    end

    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;
    // Bit 7 of each HEX byte is storage only
    assign o_io_hex0 = hex_lo[6:0];
    assign o_io_hex1 = hex_lo[14:8];
    assign o_io_hex2 = hex_lo[22:16];
    assign o_io_hex3 = hex_lo[30:24];
    assign o_io_hex4 = hex_hi[6:0];
    assign o_io_hex5 = hex_hi[14:8];
    assign o_io_hex6 = hex_hi[22:16];
    assign o_io_hex7 = hex_hi[30:24];

endmodule

// File: tb/tb_lsu_io_regs.sv
// tb/tb_lsu_io_regs.sv - randomized scoreboard bench for lsu_io_regs against a behavioural model
module tb_lsu_io_regs;

    localparam int D = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_io_valid;
    logic        i_io_wren;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic [3:0]  i_bmask;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] o_io_rdata;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
    logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
    logic [31:0] o_io_lcd;

    lsu_io_regs #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_io_valid(i_io_valid),
        .i_io_wren (i_io_wren),
        .i_lsu_addr(i_lsu_addr),
        .i_st_data (i_st_data),
        .i_bmask   (i_bmask),
        .i_io_sw   (i_io_sw),
        .i_io_btn  (i_io_btn),
        .o_io_rdata(o_io_rdata),
        .o_io_ledr (o_io_ledr),
        .o_io_ledg (o_io_ledg),
        .o_io_hex0 (o_io_hex0),
        .o_io_hex1 (o_io_hex1),
        .o_io_hex2 (o_io_hex2),
        .o_io_hex3 (o_io_hex3),
        .o_io_hex4 (o_io_hex4),
        .o_io_hex5 (o_io_hex5),
        .o_io_hex6 (o_io_hex6),
        .o_io_hex7 (o_io_hex7),
        .o_io_lcd  (o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] ledr;
        logic [31:0] ledg;
        logic [31:0] lcd;
        logic [31:0] hex_lo;
        logic [31:0] hex_hi;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Behavioural model: register file by region code, input sample histories, debounce run lengths
    logic [31:0] m_regs [0:4];
    logic [31:0] sw_hist[$];
    logic [3:0]  btn_hist[$];
    logic [3:0]  m_btn;
    int          m_run [0:3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_regs[0] = 32'h0;
        m_regs[1] = 32'h0;
        m_regs[2] = 32'h7F7F_7F7F;
        m_regs[3] = 32'h7F7F_7F7F;
        m_regs[4] = 32'h0;
        sw_hist   = '{32'h0, 32'h0};
        btn_hist  = '{4'h0, 4'h0};
        m_btn     = 4'h0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
    endtask

    // Advance the model by one rising edge using the inputs that were present before it
    task automatic model_edge();
        int code;
        if (!i_reset) return;
        code = int'(i_lsu_addr[16:12]);
        if (i_io_valid && i_io_wren && code <= 4) begin
            for (int n = 0; n < 4; n++)
                if (i_bmask[n]) m_regs[code][8*n +: 8] = i_st_data[8*n +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (btn_hist[0][b] != m_btn[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_btn[b] = ~m_btn[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        sw_hist.push_back(i_io_sw);
        void'(sw_hist.pop_front());
        btn_hist.push_back(i_io_btn);
        void'(btn_hist.pop_front());
    endtask

    function automatic logic [31:0] model_rdata(input logic v, input logic [31:0] a);
        int code;
        code = int'(a[16:12]);
        if (!v) return 32'h0;
        if (code <= 4) return m_regs[code];
        if (code == 16) return sw_hist[0];
        if (code == 17) return {28'h0, m_btn};
        return 32'h0;
    endfunction

    task automatic step(input logic rst, input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] sw, input logic [3:0] btn);
        exp_t e;
        @(posedge i_clk);
        model_edge();
        #1;
        i_reset    = rst;
        i_io_valid = v;
        i_io_wren  = w;
        i_lsu_addr = a;
        i_st_data  = d;
        i_bmask    = m;
        i_io_sw    = sw;
        i_io_btn   = btn;
        if (!rst) model_reset();
        e.rdata  = model_rdata(v, a);
        e.ledr   = m_regs[0];
        e.ledg   = m_regs[1];
        e.hex_lo = m_regs[2];
        e.hex_hi = m_regs[3];
        e.lcd    = m_regs[4];
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0, i_io_sw, i_io_btn);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b1, 1'b1, 1'b1, a, d, m, i_io_sw, i_io_btn);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata",  o_io_rdata, e.rdata);
            check("ledr",   o_io_ledr,  e.ledr);
            check("ledg",   o_io_ledg,  e.ledg);
            check("lcd",    o_io_lcd,   e.lcd);
            check("hex_lo", {1'b0, o_io_hex3, 1'b0, o_io_hex2, 1'b0, o_io_hex1, 1'b0, o_io_hex0},
                  e.hex_lo & 32'h7F7F_7F7F);
            check("hex_hi", {1'b0, o_io_hex7, 1'b0, o_io_hex6, 1'b0, o_io_hex5, 1'b0, o_io_hex4},
                  e.hex_hi & 32'h7F7F_7F7F);
        end
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  code;
        logic [3:0]  btn;
        logic [31:0] sw;

        i_reset    = 1'b0;
        i_io_valid = 1'b1;
        i_io_wren  = 1'b0;
        i_lsu_addr = 32'h1001_1000;
        i_st_data  = 32'h0;
        i_bmask    = 4'h0;
        i_io_sw    = 32'h0;
        i_io_btn   = 4'h0;
        model_reset();

        // Reset state
        @(negedge i_clk);
        check("rst_ledr",  o_io_ledr, 32'h0);
        check("rst_hex0",  {25'h0, o_io_hex0}, 32'h7F);
        check("rst_hex7",  {25'h0, o_io_hex7}, 32'h7F);
        check("rst_rdata", o_io_rdata, 32'h0);

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0);
        repeat (2) rd(32'h1001_1000);

        // Single-lane store, read through a mirrored address
        wr(32'h1000_0000, 32'hAABB_CCDD, 4'b0100);
        rd(32'h1000_0004);
        @(negedge i_clk);
        check("byte_ledr",  o_io_ledr,  32'h00BB_0000);
        check("byte_rdata", o_io_rdata, 32'h00BB_0000);

        // HEX_LO fans out to hex0..3, hex4..7 untouched
        wr(32'h1000_2000, 32'h0140_2479, 4'b1111);
        rd(32'h1000_3000);
        @(negedge i_clk);
        check("hex0", {25'h0, o_io_hex0}, 32'h79);
        check("hex1", {25'h0, o_io_hex1}, 32'h24);
        check("hex2", {25'h0, o_io_hex2}, 32'h40);
        check("hex3", {25'h0, o_io_hex3}, 32'h01);
        check("hex4", {25'h0, o_io_hex4}, 32'h7F);

        // Input and unmapped regions ignore stores
        wr(32'h1001_0000, 32'hFFFF_FFFF, 4'hF);
        wr(32'h1000_5000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h1000_5000);
        @(negedge i_clk);
        check("unmapped_rdata", o_io_rdata, 32'h0);
        check("prot_ledr", o_io_ledr, 32'h00BB_0000);

        // Switch synchronizer latency
        rd(32'h1001_0000);
        step(1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0, 32'h0000_1234, 4'h0);
        rd(32'h1001_0000);
        @(negedge i_clk);
        check("sw_1edge", o_io_rdata, 32'h0);
        rd(32'h1001_0000);
        @(negedge i_clk);
        check("sw_2edge", o_io_rdata, 32'h0000_1234);

        // Short button glitch is rejected
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'h0, i_io_sw, 4'b0001);
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'h0, i_io_sw, 4'b0000);
            @(negedge i_clk);
            check("glitch_btn", o_io_rdata, 32'h0);
        end

        // Held button is accepted on the 18th edge after the press
        step(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'h0, i_io_sw, 4'b0001);
        for (int i = 1; i <= 20; i++) begin
            rd(32'h1001_1000);
            if (i == 17) begin
                @(negedge i_clk);
                check("btn_edge17", o_io_rdata, 32'h0);
            end
            if (i == 18) begin
                @(negedge i_clk);
                check("btn_edge18", o_io_rdata, 32'h1);
            end
        end

        // Release button 0 and let it settle
        for (int i = 0; i < 25; i++)
            step(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'h0, i_io_sw, 4'b0000);

        // Reset mid-debounce restarts the full latency
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b1, 32'h1001_1000, 32'h1234_5678, 4'hF, i_io_sw, 4'b0010);
        step(1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h5555_5555, 4'hF, i_io_sw, 4'b0010);
        step(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'h0, i_io_sw, 4'b0010);
        for (int i = 1; i <= 20; i++) begin
            rd(32'h1001_1000);
            if (i == 17) begin
                @(negedge i_clk);
                check("rst_btn_edge17", o_io_rdata, 32'h0);
            end
            if (i == 18) begin
                @(negedge i_clk);
                check("rst_btn_edge18", o_io_rdata, 32'h2);
            end
        end

        // Randomized traffic
        btn = i_io_btn;
        sw  = i_io_sw;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 8))
                0: code = 5'h00;
                1: code = 5'h01;
                2: code = 5'h02;
                3: code = 5'h03;
                4: code = 5'h04;
                5: code = 5'h10;
                6: code = 5'h11;
                default: code = 5'($urandom_range(0, 31));
            endcase
            a = 32'h1000_0000 | (32'(code) << 12) | 32'($urandom_range(0, 4095));
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 19) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 15) == 0) sw = $urandom;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), sw, btn);
        end

        repeat (3) @(negedge i_clk);
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
